// File: rtl/katp91_decode_pkg.sv
// rtl/katp91_decode_pkg.sv - katp91 decode types, group codes and first-word decoder (DECODE_QUEUE_STRICT_EN)
package katp91_decode_pkg;

    typedef enum logic [3:0] {
        GRP_MATH_CONSTANT = 4'd0,
        GRP_BRANCH_JUMPS  = 4'd1,
        GRP_MATH_REG      = 4'd2,
        GRP_MATH_EREG     = 4'd3,
        GRP_SINGLE_REG    = 4'd4,
        GRP_STACK         = 4'd5,
        GRP_REG_MEMORY    = 4'd6,
        GRP_EXTENDED      = 4'd7,
        GRP_OTHERS        = 4'd8,
        GRP_RETURN        = 4'd9,
        GRP_WRONG         = 4'd15
    } group_e;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_EXT   = 1'b1
    } state_e;

    localparam logic [3:0] OP_PUSH = 4'd0;
    localparam logic [3:0] OP_POP  = 4'd1;
    localparam logic [3:0] OP_RET  = 4'd0;

    typedef struct packed {
        group_e      group;
        logic [3:0]  opr;
        logic [3:0]  rg1;
        logic [3:0]  rg2;
        logic [1:0]  erg1;
        logic [1:0]  erg2;
        logic [7:0]  val;
        logic [8:0]  jump;
        logic [15:0] ext;
        logic        reset_cycle;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // The opcode map is prefix coded: the count of trailing ones in byte 0 selects the group.
    function automatic entry_t decode_word(input logic [15:0] w);
        entry_t e;
        e = '0;
        casez (w[7:0])
            8'b???????0, 8'b??????01: begin
                e.group = GRP_MATH_CONSTANT;
                e.opr = w[3:0];
                e.rg1 = w[7:4];
                e.val = w[15:8];
                e.reset_cycle = 1'b1;
            end
            8'b?????011: begin
                e.group = GRP_BRANCH_JUMPS;
                e.opr = w[6:3];
                e.jump = w[15:7];
                e.reset_cycle = 1'b1;
            end
            8'b????0111: begin
                e.group = GRP_MATH_REG;
                e.opr = w[7:4];
                e.rg1 = w[11:8];
                e.rg2 = w[15:12];
                e.reset_cycle = 1'b1;
            end
            8'b???01111: begin
                e.group = GRP_MATH_EREG;
                e.opr = w[8:5];
                e.erg1 = w[10:9];
                e.erg2 = w[12:11];
                e.reset_cycle = 1'b1;
            end
            8'b??011111: begin
                e.opr = w[9:6];
                e.rg1 = w[13:10];
                if (w[9:6] == OP_PUSH || w[9:6] == OP_POP) begin
                    e.group = GRP_STACK;
                    e.reset_cycle = 1'b0;
                end else begin
                    e.group = GRP_SINGLE_REG;
                    e.reset_cycle = 1'b1;
                end
            end
            8'b?0111111: begin
                e.group = GRP_REG_MEMORY;
                e.opr = {1'b0, w[9:7]};
                e.rg1 = w[13:10];
                e.reset_cycle = 1'b0;
            end
            8'b01111111: begin
                e.group = GRP_EXTENDED;
                e.opr = w[11:8];
                e.reset_cycle = 1'b0;
            end
            default: begin
                e.opr = w[11:8];
                if (w[11:8] == OP_RET) begin
                    e.group = GRP_RETURN;
                    e.reset_cycle = 1'b0;
                end else begin
                    e.group = GRP_OTHERS;
                    e.reset_cycle = 1'b1;
                end
            end
        endcase
`ifdef DECODE_QUEUE_STRICT_EN
        if (((e.group == GRP_REG_MEMORY) && (w[15:14] != 2'b00)) ||
            (((e.group == GRP_EXTENDED) || (e.group == GRP_OTHERS) || (e.group == GRP_RETURN)) &&
             (w[15:12] != 4'h0))) begin
            e = '0;
            e.group = GRP_WRONG;
            e.reset_cycle = 1'b1;
        end
`endif
        return e;
    endfunction

endpackage

// File: rtl/decode_queue_fifo.sv
// rtl/decode_queue_fifo.sv - circular buffer of packed decoded entries with occupancy
module decode_queue_fifo
    import katp91_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q, wr_d, rd_d;
    logic [LVL_W-1:0]   level_q;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    assign rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_d;
            if (pop)  rd_q <= rd_d;
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !push) level_q <= level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign level = level_q;

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - katp91 two-word assembling decoder feeding a micro-op FIFO (DECODE_QUEUE_STRICT_EN)
module decode_queue
    import katp91_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [15:0]      in_word,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_group,
    output logic [3:0]       out_operator,
    output logic [3:0]       out_rg1,
    output logic [3:0]       out_rg2,
    output logic [1:0]       out_erg1,
    output logic [1:0]       out_erg2,
    output logic [7:0]       out_val,
    output logic [8:0]       out_jump,
    output logic [15:0]      out_ext,
    output logic             out_reset_cycle,
    output logic [LVL_W-1:0] out_level,
    output logic             pending_ext
);

    state_e             state_q, state_d;
    entry_t             latch_q, latch_d;
    entry_t             dec, push_entry, head_e;
    logic [ENTRY_W-1:0] head_raw;
    logic [LVL_W-1:0]   level;
    logic               accept, push, pop, two_word;

    assign dec       = decode_word(in_word);
    assign two_word  = (dec.group == GRP_REG_MEMORY) || (dec.group == GRP_EXTENDED);
    assign in_ready  = level < LVL_W'(DEPTH);
    assign out_valid = level != '0;
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        state_d    = state_q;
        latch_d    = latch_q;
        push       = 1'b0;
        push_entry = dec;
        if (flush) begin
            state_d = ST_FIRST;
        end else if (accept) begin
            case (state_q)
                ST_FIRST: begin
                    if (two_word) begin
                        latch_d = dec;
                        state_d = ST_EXT;
                    end else begin
                        push = 1'b1;
                    end
                end
                ST_EXT: begin
                    push           = 1'b1;
                    push_entry     = latch_q;
                    push_entry.ext = in_word;
                    state_d        = ST_FIRST;
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
        end
    end

    decode_queue_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .level     (level)
    );

    // Fields read as zero when the queue is empty so stale storage never leaks out.
    assign head_e = out_valid ? entry_t'(head_raw) : entry_t'('0);

    assign out_group       = head_e.group;
    assign out_operator    = head_e.opr;
    assign out_rg1         = head_e.rg1;
    assign out_rg2         = head_e.rg2;
    assign out_erg1        = head_e.erg1;
    assign out_erg2        = head_e.erg2;
    assign out_val         = head_e.val;
    assign out_jump        = head_e.jump;
    assign out_ext         = head_e.ext;
    assign out_reset_cycle = head_e.reset_cycle;
    assign out_level       = level;
    assign pending_ext     = (state_q == ST_EXT);

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Second-generation instruction decoder for the katp91 core. Accepts 16-bit instruction words over a valid/ready stream.
- Assembles the two-word forms (REG_MEMORY, EXTENDED) through a small FSM, then decodes the full prefix-coded opcode map.
- Buffers decoded micro-ops in a parametrised-depth FIFO that feeds the execute stage.
- Replaces the single-latch decoder; adds back-pressure, flush and multi-word support.

Parameters:
- DEPTH, 4, number of decoded entries buffered; any integer >= 2.
- LVL_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard buffered entries and any half-assembled instruction.
- in_valid  in  1  in_word is valid.
- in_word  in  16  instruction word; byte 0 = word[7:0].
- in_ready  out  1  word accepted when in_valid & in_ready.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- out_group  out  4  group code.
- out_operator  out  4  operator.
- out_rg1, out_rg2  out  4  register indices.
- out_erg1, out_erg2  out  2  extended-register indices.
- out_val  out  8  immediate.
- out_jump  out  9  branch offset.
- out_ext  out  16  second word; 0 for single-word forms.
- out_reset_cycle  out  1  instruction completes in one execute cycle.
- out_level  out  LVL_W  FIFO occupancy.
- pending_ext  out  1  FSM is waiting for a second word.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, FSM in FIRST.
  - All out_* fields 0, out_valid=0, out_level=0, pending_ext=0.
  - in_ready reflects the empty FIFO, so it is 1.
- in_ready = (level < DEPTH). It is independent of in_valid. A pop in the same cycle does not raise it.
- Decode is on the first word, with prefix priority from the LSB. Unassigned fields are 0.
  - byte0[0]=0 or byte0[1:0]=01: MATH_CONSTANT. operator=w[3:0], rg1=w[7:4], val=w[15:8], reset_cycle=1.
  - byte0[2:0]=011: BRANCH_JUMPS. operator=w[6:3], jump=w[15:7], reset_cycle=1.
  - byte0[3:0]=0111: MATH_REG. operator=w[7:4], rg1=w[11:8], rg2=w[15:12], reset_cycle=1.
  - byte0[4:0]=01111: MATH_EREG. operator=w[8:5], erg1=w[10:9], erg2=w[12:11], reset_cycle=1.
  - byte0[5:0]=011111: operator=w[9:6], rg1=w[13:10]. If operator is OP_PUSH or OP_POP: STACK, reset_cycle=0. Otherwise SINGLE_REG, reset_cycle=1.
  - byte0[6:0]=0111111: REG_MEMORY. operator={0,w[9:7]}, rg1=w[13:10], reset_cycle=0. Two-word form.
  - byte0=0x7F: EXTENDED. operator=w[11:8], reset_cycle=0. Two-word form.
  - byte0=0xFF: operator=w[11:8]. If operator==OP_RET: RETURN, reset_cycle=0. Otherwise OTHERS, reset_cycle=1.
- FSM states FIRST and EXT.
  - FIRST: on an accepted single-word instruction, push the decoded entry. On an accepted two-word form, latch the decoded fields, go to EXT, pending_ext=1.
  - EXT: the next accepted word becomes ext. Push the entry and return to FIRST.
- Latency: out_valid rises 1 cycle after the final word is accepted into an empty FIFO.
- FIFO: circular buffer with wrap at DEPTH. Push and pop in the same cycle leave the level unchanged. Pop on empty and push on full cannot occur, because of the handshake.
- Output fields are the head entry, valid whenever out_valid=1. They hold while out_ready=0.
- flush has priority over push and pop. Next cycle: level=0, FSM=FIRST, pending_ext=0. A word presented while flush=1 is dropped.
- Reset mid-EXT discards the partial instruction.

Optional Feature:
- Macro DECODE_QUEUE_STRICT_EN.
- Defined:
  - Reserved bits must be 0: REG_MEMORY w[15:14]; EXTENDED and OTHERS/RETURN w[15:12].
  - A nonzero reserved bit gives GROUP_WRONG, operator=0, reset_cycle=1, and no second word is consumed.
- Undefined: reserved bits are ignored; GROUP_WRONG is never produced.

Decomposition:
- Package katp91_decode_pkg holds:
  - Group codes: MATH_CONSTANT=0, BRANCH_JUMPS=1, MATH_REG=2, MATH_EREG=3, SINGLE_REG=4, STACK=5, REG_MEMORY=6, EXTENDED=7, OTHERS=8, RETURN=9, WRONG=15.
  - OP_PUSH=0, OP_POP=1, OP_RET=0.
  - The packed decoded-entry struct.
- One sub-module, decode_queue_fifo: parametrised DEPTH storage of the packed entry, exposing level.

Test Plan:
- After reset, in_word=16'h3412 accepted → 1 cycle later out_valid=1, group=0, rg1=1, val=8'h34, operator=2, reset_cycle=1.
- 16'h0A1B → group=1, operator=3, jump=9'h014.
- 16'h037F then 16'hBEEF → pending_ext=1 between the two words; single entry group=7, operator=3, ext=16'hBEEF. With out_ready held 0 for the entire test, only one entry is created.
- 16'h001F → group=5, operator=0, reset_cycle=0. Then 16'h00FF → group=9. Then 16'h01FF → group=8, operator=1.
- DEPTH=4, out_ready=0, 5 words offered → in_ready drops after the 4th word and the 5th is held. Pulse out_ready for 1 cycle → head popped, 5th word accepted, level stays 4, FIFO order intact across pointer wrap.
- Send 16'h037F, then flush in the EXT state → pending_ext=0, level=0. A following 16'h3412 decodes as MATH_CONSTANT. Under DECODE_QUEUE_STRICT_EN, 16'h107F → GROUP_WRONG and no ext word is consumed.
